// File: rtl/convolution_2d_result_writer_pkg.sv
// Shared definitions for the convolution result writer: FSM state encoding
// and word-size helpers.
package convolution_2d_result_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/convolution_2d_result_writer_if.sv
// Result stream (valid/ready) and memory write-request bus of the result writer.
// slave = the writer, master = the stream producer / memory side.
interface convolution_2d_result_writer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 32
);

  logic                  in_ready;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic [USER_WIDTH-1:0] in_user;
  logic                  in_last;
  logic                  in_overflow;
  logic                  wr_req;
  logic                  wr_ack;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [USER_WIDTH-1:0] wr_be;

  modport slave (
    output in_ready,
    input  in_valid, in_data, in_user, in_last, in_overflow,
    output wr_req, wr_addr, wr_data, wr_be,
    input  wr_ack
  );

  modport master (
    input  in_ready,
    output in_valid, in_data, in_user, in_last, in_overflow,
    input  wr_req, wr_addr, wr_data, wr_be,
    output wr_ack
  );

endinterface

// File: rtl/convolution_2d_result_addr_gen.sv
// Write address generator: holds the base/next address and beat index,
// registers the address of each accepted beat and flags the final beat.
module convolution_2d_result_addr_gen
  import convolution_2d_result_writer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] num_items,
  input  logic                   advance,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic                   is_last
);

  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(bytes_per_word(DATA_WIDTH));

  logic [ADDR_WIDTH-1:0]  next_addr_r;
  logic [ADDR_WIDTH-1:0]  wr_addr_r;
  logic [COUNT_WIDTH-1:0] idx_r;
  logic [COUNT_WIDTH-1:0] last_idx_r;

  // Incremental address walk avoids an index multiplier; wraps mod 2^ADDR_WIDTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_addr_r <= '0;
      wr_addr_r   <= '0;
      idx_r       <= '0;
      last_idx_r  <= '0;
    end else if (load) begin
      next_addr_r <= base_addr;
      idx_r       <= '0;
      last_idx_r  <= num_items - COUNT_WIDTH'(1);
    end else if (advance) begin
      wr_addr_r   <= next_addr_r;
      next_addr_r <= next_addr_r + STRIDE;
      idx_r       <= idx_r + COUNT_WIDTH'(1);
    end
  end

  assign wr_addr = wr_addr_r;
  assign is_last = (idx_r == last_idx_r);

endmodule

// File: rtl/convolution_2d_result_writer.sv
// Tail of the 2-D convolution pipeline: writes each result beat to consecutive
// words from a programmed base, checks LAST placement, reports completion.
module convolution_2d_result_writer
  import convolution_2d_result_writer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int USER_WIDTH  = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    go,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [COUNT_WIDTH-1:0]  num_items,
  output logic                    busy,
  output logic                    done,
  output logic                    error_last,
  output logic                    overflow_seen,
  convolution_2d_result_writer_if.slave bus
);

  state_t                state_r;
  state_t                state_s;
  logic                  go_accept_s;
  logic                  in_ready_s;
  logic                  accept_s;
  logic                  is_last_s;
  logic                  wr_req_r;
  logic [DATA_WIDTH-1:0] wr_data_r;
  logic [USER_WIDTH-1:0] wr_be_r;
  logic                  error_last_r;
  logic                  overflow_seen_r;

  assign go_accept_s = go && (state_r == ST_IDLE);
  // A new beat may be taken while the current write retires in the same cycle.
  assign in_ready_s  = (state_r == ST_RUN) && (!wr_req_r || bus.wr_ack);
  assign accept_s    = bus.in_valid && in_ready_s;

  convolution_2d_result_addr_gen #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (go_accept_s),
    .base_addr (base_addr),
    .num_items (num_items),
    .advance   (accept_s),
    .wr_addr   (bus.wr_addr),
    .is_last   (is_last_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (go) begin
          state_s = (num_items == '0) ? ST_DONE : ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && is_last_s) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (!wr_req_r || bus.wr_ack) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Write request register: load on accept, retire on ack, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_req_r  <= 1'b0;
      wr_data_r <= '0;
      wr_be_r   <= '0;
    end else if (accept_s) begin
      wr_req_r  <= 1'b1;
      wr_data_r <= bus.in_data;
      wr_be_r   <= bus.in_user;
    end else if (bus.wr_ack) begin
      wr_req_r  <= 1'b0;
    end
  end

  // Sticky status flags, cleared by an accepted GO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error_last_r    <= 1'b0;
      overflow_seen_r <= 1'b0;
    end else if (go_accept_s) begin
      error_last_r    <= 1'b0;
      overflow_seen_r <= 1'b0;
    end else if (accept_s) begin
      error_last_r    <= error_last_r | (bus.in_last != is_last_s);
      overflow_seen_r <= overflow_seen_r | bus.in_overflow;
    end
  end

  assign busy          = (state_r == ST_RUN) || (state_r == ST_FLUSH);
  assign done          = (state_r == ST_DONE);
  assign error_last    = error_last_r;
  assign overflow_seen = overflow_seen_r;
  assign bus.in_ready  = in_ready_s;
  assign bus.wr_req    = wr_req_r;
  assign bus.wr_data   = wr_data_r;
  assign bus.wr_be     = wr_be_r;

endmodule

// File: tb/tb_convolution_2d_result_writer.sv
// Self-checking bench for convolution_2d_result_writer: table of directed jobs,
// randomized jobs, and hand-written reset/GO sequences against a job-level model.
module tb_convolution_2d_result_writer;

  localparam int DW = 32;
  localparam int UW = 4;
  localparam int AW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          go;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_items;
  logic          busy;
  logic          done;
  logic          error_last;
  logic          overflow_seen;

  convolution_2d_result_writer_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .ADDR_WIDTH(AW)) bus_if ();

  convolution_2d_result_writer #(
    .DATA_WIDTH(DW), .USER_WIDTH(UW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .go            (go),
    .base_addr     (base_addr),
    .num_items     (num_items),
    .busy          (busy),
    .done          (done),
    .error_last    (error_last),
    .overflow_seen (overflow_seen),
    .bus           (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Job-level reference model: beats accepted so far, pending write contents.
  bit          m_active, m_done, m_pending, m_err, m_ovf;
  int          m_cnt;
  int          m_num;
  logic [31:0] m_base, m_addr, m_data;
  logic [3:0]  m_be;

  logic [31:0] b_data [0:31];
  logic [3:0]  b_user [0:31];
  bit          b_last [0:31];
  bit          b_ovf  [0:31];
  int          dut_writes, dut_dones;

  typedef struct {
    logic [31:0] base;
    int          num;
    int          ack_period;   // 0: random ack
    int          valid_pct;
    int          last_at;      // -1 correct, -2 random, else only this beat
    int          ovf_at;       // -1 none, -2 random, else this beat
    int          user0;        // -1 random, else BE of beat 0
    int          exp_err;      // -1 not checked
    int          exp_ovf;
    int          exp_cycles;   // 0 not checked
  } job_t;

  job_t jobs [0:6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_pending = 0; m_err = 0; m_ovf = 0;
    m_cnt = 0; m_num = 0; m_base = '0; m_addr = '0; m_data = '0; m_be = '0;
  endtask

  // One clock: drive at negedge, compare, then advance the model over the edge.
  task automatic step(input bit go_v, input bit valid_v, input bit ack_v);
    int bi;
    bit exp_ready, accept, pend_was, cnt_full;
    bi = (m_cnt < 32) ? m_cnt : 31;
    go                 = go_v;
    bus_if.in_valid    = valid_v;
    bus_if.in_data     = b_data[bi];
    bus_if.in_user     = b_user[bi];
    bus_if.in_last     = b_last[bi];
    bus_if.in_overflow = b_ovf[bi];
    bus_if.wr_ack      = ack_v;
    #1;
    exp_ready = m_active && (m_cnt < m_num) && (!m_pending || ack_v);
    check("in_ready", 32'(bus_if.in_ready), 32'(exp_ready));
    check("wr_req", 32'(bus_if.wr_req), 32'(m_pending));
    if (m_pending) begin
      check("wr_addr", bus_if.wr_addr, m_addr);
      check("wr_data", bus_if.wr_data, m_data);
      check("wr_be", 32'(bus_if.wr_be), 32'(m_be));
    end
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_done));
    check("error_last", 32'(error_last), 32'(m_err));
    check("overflow_seen", 32'(overflow_seen), 32'(m_ovf));
    if (bus_if.wr_req && ack_v) dut_writes++;
    if (done) dut_dones++;
    @(posedge clk);
    accept   = exp_ready && valid_v;
    pend_was = m_pending;
    cnt_full = (m_cnt == m_num);
    if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (go_v) begin
        m_base = base_addr; m_num = int'(num_items); m_cnt = 0; m_err = 0; m_ovf = 0;
        if (num_items == 16'd0) m_done = 1;
        else m_active = 1;
      end
    end else begin
      if (accept) begin
        m_addr = m_base + 32'(m_cnt) * 32'd4;
        m_data = b_data[bi];
        m_be   = b_user[bi];
        if (b_last[bi] != (m_cnt == m_num - 1)) m_err = 1;
        if (b_ovf[bi]) m_ovf = 1;
        m_pending = 1;
        m_cnt++;
      end else if (ack_v) begin
        m_pending = 0;
      end
      if (cnt_full && (!pend_was || ack_v)) begin
        m_active = 0;
        m_done   = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_job(input job_t j, input string tag);
    bit seen_done, ack_v, valid_v, go_v;
    int cyc;
    for (int i = 0; i < 32; i++) begin
      b_data[i] = $urandom;
      b_user[i] = 4'($urandom);
      if (j.ovf_at == -2) b_ovf[i] = ($urandom_range(4, 0) == 0);
      else                b_ovf[i] = (i == j.ovf_at);
      if (j.last_at == -1)      b_last[i] = (i == j.num - 1);
      else if (j.last_at == -2) b_last[i] = ($urandom_range(4, 0) == 0) ? 1'($urandom) : (i == j.num - 1);
      else                      b_last[i] = (i == j.last_at);
    end
    if (j.user0 >= 0) b_user[0] = 4'(j.user0);
    base_addr  = j.base;
    num_items  = 16'(j.num);
    dut_writes = 0;
    dut_dones  = 0;
    step(1'b1, 1'b0, 1'b0);
    // Inputs are only sampled on GO; scramble them for the rest of the job.
    base_addr = $urandom;
    num_items = 16'($urandom);
    seen_done = 0;
    cyc = 1;
    while (!seen_done && cyc < 400) begin
      ack_v   = (j.ack_period == 0) ? 1'($urandom) : ((cyc % j.ack_period) == 0);
      valid_v = ($urandom_range(99, 0) < j.valid_pct);
      go_v    = m_active && ((cyc == 2) || ($urandom_range(5, 0) == 0));
      if (m_done) begin
        seen_done = 1;
        if (j.exp_cycles > 0) check({tag, "_done_cycle"}, 32'(cyc), 32'(j.exp_cycles));
      end
      step(go_v, valid_v, ack_v);
      cyc++;
    end
    check({tag, "_completed"}, 32'(seen_done), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check({tag, "_writes"}, 32'(dut_writes), 32'(j.num));
    check({tag, "_done_pulses"}, 32'(dut_dones), 32'd1);
    if (j.exp_err >= 0) check({tag, "_error_last"}, 32'(error_last), 32'(j.exp_err));
    if (j.exp_ovf >= 0) check({tag, "_overflow_seen"}, 32'(overflow_seen), 32'(j.exp_ovf));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t rj;
    jobs[0] = '{32'h0000_1000, 4, 1, 100, -1, -1, -1, 0, 0, 6};
    jobs[1] = '{32'h0000_1000, 4, 3, 100, -1, -1, -1, 0, 0, 0};
    jobs[2] = '{32'h0000_2000, 3, 1, 100,  1, -1, -1, 1, 0, 0};
    jobs[3] = '{32'h0000_3000, 4, 2, 100, -1,  1,  3, 0, 1, 0};
    jobs[4] = '{32'h0000_4000, 0, 1, 100, -1, -1, -1, 0, 0, 1};
    jobs[5] = '{32'hFFFF_FFF8, 4, 0,  60, -1, -1, -1, 0, 0, 0};
    jobs[6] = '{32'h0000_0102, 1, 1, 100, -1, -1, -1, 0, 0, 3};

    reset_n = 1'b0; go = 1'b0; base_addr = '0; num_items = '0;
    bus_if.in_valid = 1'b0; bus_if.in_data = '0; bus_if.in_user = '0;
    bus_if.in_last = 1'b0; bus_if.in_overflow = 1'b0; bus_if.wr_ack = 1'b0;
    for (int i = 0; i < 32; i++) begin
      b_data[i] = '0; b_user[i] = '0; b_last[i] = 0; b_ovf[i] = 0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
    check("rst_wr_req", 32'(bus_if.wr_req), 32'd0);
    check("rst_wr_addr", bus_if.wr_addr, 32'd0);
    check("rst_wr_data", bus_if.wr_data, 32'd0);
    check("rst_wr_be", 32'(bus_if.wr_be), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error_last", 32'(error_last), 32'd0);
    check("rst_overflow_seen", 32'(overflow_seen), 32'd0);
    reset_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 7; t++) begin
      run_job(jobs[t], $sformatf("job%0d", t));
      repeat (2) step(1'b0, 1'b0, 1'b0);
    end

    // Reset while a write is pending: outputs drop asynchronously, no DONE.
    for (int i = 0; i < 32; i++) begin
      b_data[i] = $urandom; b_user[i] = 4'hF; b_last[i] = (i == 4); b_ovf[i] = 1;
    end
    base_addr = 32'h0000_5000; num_items = 16'd5;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    bus_if.in_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("midrst_wr_req", 32'(bus_if.wr_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(bus_if.in_ready), 32'd0);
    check("midrst_overflow_seen", 32'(overflow_seen), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    dut_dones = 0;
    repeat (4) step(1'b0, 1'b1, 1'b1);
    check("midrst_no_done", 32'(dut_dones), 32'd0);
    run_job(jobs[0], "post_reset");

    for (int r = 0; r < 15; r++) begin
      rj.base       = $urandom;
      rj.num        = $urandom_range(12, 1);
      rj.ack_period = $urandom_range(3, 0);
      rj.valid_pct  = $urandom_range(100, 30);
      rj.last_at    = -2;
      rj.ovf_at     = -2;
      rj.user0      = -1;
      rj.exp_err    = -1;
      rj.exp_ovf    = -1;
      rj.exp_cycles = 0;
      run_job(rj, $sformatf("rand%0d", r));
      repeat ($urandom_range(2, 0)) step(1'b0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
